// File: rtl/lsu_mem_stage_if.sv
// Signal bundle between the execute stage, the data-memory port and writeback.
// The master modport is the load/store unit; slave is its environment.
interface lsu_mem_stage_if;
    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;

    // data-memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // retirement / writeback
    logic        done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;

    modport master (
        input  req_valid, alucode, addr, store_data, rd_in,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output done, wb_valid, wb_rd, wb_data, exc_valid, exc_code
    );

    modport slave (
        output req_valid, alucode, addr, store_data, rd_in,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  done, wb_valid, wb_rd, wb_data, exc_valid, exc_code
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: single-outstanding req/ack memory access with lane steering,
// load extension, misalignment and timeout exceptions.
module lsu_mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_stage_if.master bus
);
    // Memory operation codes, matching define.vh
    localparam logic [5:0] ALU_LB  = 6'd10;
    localparam logic [5:0] ALU_LH  = 6'd11;
    localparam logic [5:0] ALU_LW  = 6'd12;
    localparam logic [5:0] ALU_LBU = 6'd13;
    localparam logic [5:0] ALU_LHU = 6'd14;
    localparam logic [5:0] ALU_SB  = 6'd15;
    localparam logic [5:0] ALU_SH  = 6'd16;
    localparam logic [5:0] ALU_SW  = 6'd17;

    localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] EXC_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT        = 2'd2;

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_reg,     state_next;
    logic [15:0] cnt_reg,       cnt_next;
    logic [5:0]  op_reg,        op_next;
    logic [1:0]  off_reg,       off_next;
    logic [4:0]  rd_reg,        rd_next;
    logic        mem_req_reg,   mem_req_next;
    logic        mem_we_reg,    mem_we_next;
    logic [31:0] mem_addr_reg,  mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [3:0]  mem_be_reg,    mem_be_next;
    logic        exc_pend_reg,  exc_pend_next;
    logic [1:0]  exc_code_reg,  exc_code_next;
    logic        wb_pend_reg,   wb_pend_next;
    logic [4:0]  wb_rd_reg,     wb_rd_next;
    logic [31:0] wb_data_reg,   wb_data_next;

    // Decode of the incoming request
    logic        in_is_mem;
    logic        in_is_load;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    always_comb begin
        in_is_mem     = 1'b0;
        in_is_load    = 1'b0;
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_wdata      = 32'h0;
        case (bus.alucode)
            ALU_LB, ALU_LBU: begin
                in_is_mem  = 1'b1;
                in_is_load = 1'b1;
            end
            ALU_LH, ALU_LHU: begin
                in_is_mem     = 1'b1;
                in_is_load    = 1'b1;
                in_misaligned = bus.addr[0];
            end
            ALU_LW: begin
                in_is_mem     = 1'b1;
                in_is_load    = 1'b1;
                in_misaligned = |bus.addr[1:0];
            end
            ALU_SB: begin
                in_is_mem = 1'b1;
                in_be     = 4'b0001 << bus.addr[1:0];
                in_wdata  = {4{bus.store_data[7:0]}};
            end
            ALU_SH: begin
                in_is_mem     = 1'b1;
                in_misaligned = bus.addr[0];
                in_be         = 4'b0011 << bus.addr[1:0];
                in_wdata      = {2{bus.store_data[15:0]}};
            end
            ALU_SW: begin
                in_is_mem     = 1'b1;
                in_misaligned = |bus.addr[1:0];
                in_wdata      = bus.store_data;
            end
            default: ;
        endcase
    end

    // Load extraction from the returned word, using the latched byte offset
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;
    logic        op_is_load;

    always_comb begin
        rdata_shifted = bus.mem_rdata >> {off_reg, 3'b000};
        op_is_load    = 1'b1;
        case (op_reg)
            ALU_LB:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            ALU_LBU: load_ext = {24'h0, rdata_shifted[7:0]};
            ALU_LH:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            ALU_LHU: load_ext = {16'h0, rdata_shifted[15:0]};
            ALU_LW:  load_ext = rdata_shifted;
            default: begin
                load_ext   = rdata_shifted;
                op_is_load = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        off_next       = off_reg;
        rd_next        = rd_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_be_next    = mem_be_reg;
        exc_pend_next  = exc_pend_reg;
        exc_code_next  = exc_code_reg;
        wb_pend_next   = wb_pend_reg;
        wb_rd_next     = wb_rd_reg;
        wb_data_next   = wb_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid && in_is_mem) begin
                    op_next  = bus.alucode;
                    off_next = bus.addr[1:0];
                    rd_next  = bus.rd_in;
                    wb_pend_next = 1'b0;
                    if (in_misaligned) begin
                        // Never touches memory; retire straight away with an exception
                        state_next    = S_DONE;
                        exc_pend_next = 1'b1;
                        exc_code_next = in_is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
                        wb_rd_next    = bus.rd_in;
                    end else begin
                        state_next     = S_REQ;
                        cnt_next       = 16'h0;
                        exc_pend_next  = 1'b0;
                        mem_req_next   = 1'b1;
                        mem_we_next    = ~in_is_load;
                        mem_addr_next  = {bus.addr[31:2], 2'b00};
                        mem_wdata_next = in_wdata;
                        mem_be_next    = in_be;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    state_next   = S_DONE;
                    mem_req_next = 1'b0;
                    wb_rd_next   = rd_reg;
                    if (op_is_load) begin
                        wb_data_next = load_ext;
                        wb_pend_next = (rd_reg != 5'd0);
                    end
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next    = S_DONE;
                    mem_req_next  = 1'b0;
                    exc_pend_next = 1'b1;
                    exc_code_next = EXC_TIMEOUT;
                    wb_rd_next    = rd_reg;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_DONE: begin
                state_next    = S_IDLE;
                exc_pend_next = 1'b0;
                wb_pend_next  = 1'b0;
            end
            default: begin
                state_next   = S_IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 16'h0;
            op_reg        <= 6'h0;
            off_reg       <= 2'h0;
            rd_reg        <= 5'h0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            mem_be_reg    <= 4'h0;
            exc_pend_reg  <= 1'b0;
            exc_code_reg  <= 2'h0;
            wb_pend_reg   <= 1'b0;
            wb_rd_reg     <= 5'h0;
            wb_data_reg   <= 32'h0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            off_reg       <= off_next;
            rd_reg        <= rd_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_be_reg    <= mem_be_next;
            exc_pend_reg  <= exc_pend_next;
            exc_code_reg  <= exc_code_next;
            wb_pend_reg   <= wb_pend_next;
            wb_rd_reg     <= wb_rd_next;
            wb_data_reg   <= wb_data_next;
        end
    end

    // Retirement pulses exist only while in DONE
    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.exc_valid = (state_reg == S_DONE) && exc_pend_reg;
    assign bus.wb_valid  = (state_reg == S_DONE) && wb_pend_reg;
    assign bus.exc_code  = exc_code_reg;
    assign bus.wb_rd     = wb_rd_reg;
    assign bus.wb_data   = wb_data_reg;

    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table for single operations plus
// hand sequences for timeout, reset abort and back-to-back issue.
module tb_lsu_mem_stage;
    localparam logic [5:0] ALU_LB  = 6'd10;
    localparam logic [5:0] ALU_LH  = 6'd11;
    localparam logic [5:0] ALU_LW  = 6'd12;
    localparam logic [5:0] ALU_LBU = 6'd13;
    localparam logic [5:0] ALU_LHU = 6'd14;
    localparam logic [5:0] ALU_SB  = 6'd15;
    localparam logic [5:0] ALU_SH  = 6'd16;
    localparam logic [5:0] ALU_SW  = 6'd17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  code;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic        exp_exc;
        logic [1:0]  exp_code;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        check("ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.alucode    = v.code;
        bus.addr       = v.addr;
        bus.store_data = v.sdata;
        bus.rd_in      = v.rd;
        tick();
        bus.req_valid = 1'b0;
        if (v.exp_exc) begin
            check("mis_mem_req", 32'(bus.mem_req), 32'd0);
            check("mis_done", 32'(bus.done), 32'd1);
            check("mis_exc_valid", 32'(bus.exc_valid), 32'd1);
            check("mis_exc_code", 32'(bus.exc_code), 32'(v.exp_code));
            check("mis_wb_valid", 32'(bus.wb_valid), 32'd0);
        end else begin
            check("req_high", 32'(bus.mem_req), 32'd1);
            check("req_addr", bus.mem_addr, {v.addr[31:2], 2'b00});
            check("req_be", 32'(bus.mem_be), 32'(v.exp_be));
            check("req_we", 32'(bus.mem_we), 32'(v.exp_we));
            check("req_wdata", bus.mem_wdata, v.exp_wdata);
            for (int i = 0; i < v.delay; i++) begin
                tick();
                check("req_hold", 32'(bus.mem_req), 32'd1);
                check("req_no_done", 32'(bus.done), 32'd0);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rdata;
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            check("ack_mem_req", 32'(bus.mem_req), 32'd0);
            check("ack_done", 32'(bus.done), 32'd1);
            check("ack_exc_valid", 32'(bus.exc_valid), 32'd0);
            check("ack_wb_valid", 32'(bus.wb_valid), 32'(v.exp_wb));
            if (v.exp_wb) begin
                check("ack_wb_rd", 32'(bus.wb_rd), 32'(v.rd));
                check("ack_wb_data", bus.wb_data, v.exp_wb_data);
            end
        end
        tick();
        check("done_single", 32'(bus.done), 32'd0);
        check("ready_after", 32'(bus.req_ready), 32'd1);
        $display("txn %0d: code=%0d addr=%h wb_data=%h exc=%0d code=%0d",
                 idx, v.code, v.addr, bus.wb_data, v.exp_exc, bus.exc_code);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // code addr sdata rd rdata delay exc code be we wdata wb wb_data
        vecs[0]  = '{ALU_LB,  32'h0000_1003, 32'h0,         5'd5,  32'h8012_3456, 2, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{ALU_LHU, 32'h0000_2002, 32'h0,         5'd6,  32'hBEEF_1234, 0, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_BEEF};
        vecs[2]  = '{ALU_LH,  32'h0000_2002, 32'h0,         5'd7,  32'hBEEF_1234, 0, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hFFFF_BEEF};
        vecs[3]  = '{ALU_SH,  32'h0000_3002, 32'h1234_ABCD, 5'd8,  32'h0,         1, 1'b0, 2'd0, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b0, 32'h0};
        vecs[4]  = '{ALU_LW,  32'h0000_4002, 32'h0,         5'd9,  32'h0,         0, 1'b1, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[5]  = '{ALU_SW,  32'h0000_4001, 32'h5555_AAAA, 5'd9,  32'h0,         0, 1'b1, 2'd1, 4'b1111, 1'b1, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{ALU_SB,  32'h0000_5001, 32'h0000_00A5, 5'd1,  32'h0,         0, 1'b0, 2'd0, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[7]  = '{ALU_LBU, 32'h0000_6001, 32'h0,         5'd2,  32'h1122_F344, 1, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_00F3};
        vecs[8]  = '{ALU_LB,  32'h0000_6001, 32'h0,         5'd3,  32'h1122_F344, 0, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF3};
        vecs[9]  = '{ALU_LW,  32'h0000_7000, 32'h0,         5'd0,  32'hDEAD_BEEF, 0, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[10] = '{ALU_SW,  32'h0000_8000, 32'hCAFE_F00D, 5'd4,  32'h0,         2, 1'b0, 2'd0, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[11] = '{ALU_LH,  32'h0000_9001, 32'h0,         5'd10, 32'h0,         0, 1'b1, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[12] = '{ALU_SH,  32'h0000_9003, 32'h0,         5'd11, 32'h0,         0, 1'b1, 2'd1, 4'b1111, 1'b1, 32'h0,         1'b0, 32'h0};
        vecs[13] = '{ALU_LW,  32'h0000_A004, 32'h0,         5'd31, 32'h7FFF_8000, 0, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h7FFF_8000};
        vecs[14] = '{ALU_LHU, 32'h0000_B000, 32'h0,         5'd12, 32'h1234_8001, 1, 1'b0, 2'd0, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_8001};

        bus.req_valid  = 1'b0;
        bus.alucode    = 6'd0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.rd_in      = 5'd0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;

        // Reset values
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);

        // Non-memory code and a stray ack are both ignored in IDLE
        bus.req_valid = 1'b1;
        bus.alucode   = 6'd3;
        bus.mem_ack   = 1'b1;
        tick();
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        check("nonmem_ready", 32'(bus.req_ready), 32'd1);
        check("nonmem_mem_req", 32'(bus.mem_req), 32'd0);
        check("nonmem_done", 32'(bus.done), 32'd0);
        $display("txn nonmem: code=3 ignored, ready=%0d", bus.req_ready);

        for (int i = 0; i < 15; i++) apply_vec(i, vecs[i]);

        // Timeout: SW with no ack, mem_req high for exactly 4 cycles
        bus.req_valid  = 1'b1;
        bus.alucode    = ALU_SW;
        bus.addr       = 32'h0000_C000;
        bus.store_data = 32'h0000_0055;
        bus.rd_in      = 5'd13;
        tick();
        bus.req_valid = 1'b0;
        check("to_req_c1", 32'(bus.mem_req), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("to_req_hold", 32'(bus.mem_req), 32'd1);
            check("to_no_done", 32'(bus.done), 32'd0);
        end
        tick();
        check("to_mem_req_drop", 32'(bus.mem_req), 32'd0);
        check("to_done", 32'(bus.done), 32'd1);
        check("to_exc_valid", 32'(bus.exc_valid), 32'd1);
        check("to_exc_code", 32'(bus.exc_code), 32'd2);
        tick();
        check("to_ready", 32'(bus.req_ready), 32'd1);
        $display("txn timeout: SW addr=0000c000 exc_code=%0d", bus.exc_code);

        // Ack on the would-be timeout edge wins
        bus.req_valid = 1'b1;
        bus.alucode   = ALU_LW;
        bus.addr      = 32'h0000_C100;
        bus.rd_in     = 5'd14;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("ta_req_hold", 32'(bus.mem_req), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0102_0304;
        tick();
        bus.mem_ack   = 1'b0;
        check("ta_done", 32'(bus.done), 32'd1);
        check("ta_exc_valid", 32'(bus.exc_valid), 32'd0);
        check("ta_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("ta_wb_data", bus.wb_data, 32'h0102_0304);
        tick();
        $display("txn ack_at_limit: LW wb_data=%h", bus.wb_data);

        // Asynchronous reset while in REQ
        bus.req_valid = 1'b1;
        bus.alucode   = ALU_LW;
        bus.addr      = 32'h0000_E000;
        bus.rd_in     = 5'd15;
        tick();
        bus.req_valid = 1'b0;
        check("ra_req_high", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ra_mem_req_async", 32'(bus.mem_req), 32'd0);
        check("ra_ready_async", 32'(bus.req_ready), 32'd1);
        tick();
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        check("ra_no_done", 32'(bus.done), 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        check("ra_no_done2", 32'(bus.done), 32'd0);
        check("ra_mem_req", 32'(bus.mem_req), 32'd0);
        $display("txn reset_abort: mem_req=%0d done=%0d", bus.mem_req, bus.done);

        // Back-to-back LW with ack on the first REQ cycle
        bus.req_valid = 1'b1;
        bus.alucode   = ALU_LW;
        bus.addr      = 32'h0000_D000;
        bus.rd_in     = 5'd3;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        tick();
        check("bb1_req", 32'(bus.mem_req), 32'd1);
        check("bb1_ready_low", 32'(bus.req_ready), 32'd0);
        bus.addr  = 32'h0000_D004;
        bus.rd_in = 5'd4;
        tick();
        check("bb1_done", 32'(bus.done), 32'd1);
        check("bb1_wb_rd", 32'(bus.wb_rd), 32'd3);
        check("bb1_wb_data", bus.wb_data, 32'h1111_1111);
        check("bb1_ready_low2", 32'(bus.req_ready), 32'd0);
        bus.mem_rdata = 32'h2222_2222;
        tick();
        check("bb_gap_ready", 32'(bus.req_ready), 32'd1);
        check("bb_gap_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        check("bb2_req", 32'(bus.mem_req), 32'd1);
        tick();
        bus.mem_ack = 1'b0;
        check("bb2_done", 32'(bus.done), 32'd1);
        check("bb2_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("bb2_wb_rd", 32'(bus.wb_rd), 32'd4);
        check("bb2_wb_data", bus.wb_data, 32'h2222_2222);
        tick();
        $display("txn back_to_back: last wb_rd=%0d wb_data=%h", bus.wb_rd, bus.wb_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
